imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 14 +
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: header/word/byte widths, packer count width, loader state enum.
package imem_loader_pkg;

  localparam int HDR_W          = 16;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int CNT_W          = 3;  // holds 0..BYTES_PER_WORD

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// Latency: n/a (wires only). Backpressure: sink drops in_ready to stall the source.
// Ports: in_valid/in_data driven by master (source), in_ready driven by slave (loader).
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_byte_packer.sv
// 4-byte big-endian shift register: first pushed byte ends up in bits 31:24.
// Latency: word_o/cnt_o/full_o reflect a push on the following cycle. Backpressure: pushes ignored while full.
// Ports: clk, rst_n, clr_i (drop count), push_i/byte_i (new byte), word_o, cnt_o, full_o.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              full_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign full_o = (cnt_q == CNT_W'(BYTES_PER_WORD));
  assign word_o = word_q;
  assign cnt_o  = cnt_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (push_i && !full_o) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a big-endian word-count header then streams words into IMEM, then releases the core.
// Latency: one WRITE cycle after each 4th data byte; cpu_run rises the cycle after the last write.
// Backpressure: in_ready low outside HDR_HI/HDR_LO/DATA; in_valid low simply stalls, no timeout.
// Ports: clk, rst_n, start, s_if (byte stream), imem_we/imem_addr/imem_wdata, cpu_run, done, err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  imem_loader_if.slave s_if,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        err
);

  // One extra bit so IMEM_WORDS up to 65536 compares correctly against a 16-bit count.
  localparam logic [HDR_W:0] MAX_N = (HDR_W + 1)'(IMEM_WORDS);

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  n_q, n_d;
  logic [HDR_W-1:0]  k_q, k_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              last_word;
  logic [HDR_W-1:0]  n_hdr;
  logic [31:0]       wr_addr;

  logic              pk_clr, pk_push, pk_full;
  logic [WORD_W-1:0] pk_word;
  logic [CNT_W-1:0]  pk_cnt;

  imem_loader_byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pk_clr),
    .push_i (pk_push),
    .byte_i (s_if.in_data),
    .word_o (pk_word),
    .cnt_o  (pk_cnt),
    .full_o (pk_full)
  );

  assign s_if.in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign accept        = s_if.in_valid && s_if.in_ready;
  assign n_hdr         = {n_q[HDR_W-1:BYTE_W], s_if.in_data};
  assign last_word     = (k_q == n_q - HDR_W'(1));
  // Byte address of word k; the 32-bit add wraps naturally.
  assign wr_addr       = BASE_ADDR + {{(32-HDR_W-2){1'b0}}, k_q, 2'b00};

  // During WRITE the live word/address are shown; otherwise the last written values are held.
  assign imem_we    = (state_q == S_WRITE) && pk_full;
  assign imem_addr  = imem_we ? wr_addr : addr_q;
  assign imem_wdata = imem_we ? pk_word : wdata_q;
  assign done       = imem_we && last_word;
  assign cpu_run    = (state_q == S_RUN);
  assign err        = (state_q == S_ERROR);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pk_clr  = 1'b0;
    pk_push = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d = S_HDR_HI;
          n_d     = '0;
          k_d     = '0;
          pk_clr  = 1'b1;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d     = {s_if.in_data, BYTE_W'(0)};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d = n_hdr;
          if (n_hdr == '0 || {1'b0, n_hdr} > MAX_N) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
            k_d     = '0;
            pk_clr  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          pk_push = 1'b1;
          if (pk_cnt == CNT_W'(BYTES_PER_WORD - 1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = wr_addr;
        wdata_d = pk_word;
        pk_clr  = 1'b1;
        if (last_word) begin
          state_d = S_RUN;
        end else begin
          k_d     = k_q + HDR_W'(1);
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised and directed checks of imem_loader against a stream-level reference model.
// Latency: n/a. Backpressure: the driver holds each byte until it is accepted.
// Ports: none (top-level bench).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        done;
  logic        err;

  imem_loader_if bus();

  imem_loader #(.IMEM_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_if       (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: counts accepted bytes, done pulses and records every write.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          acc_cnt  = 0;
  int          done_cnt = 0;
  logic        done_seen = 1'b0;

  always @(negedge clk) begin
    if (done_seen) check_val("cpu_run_after_done", {63'd0, cpu_run}, 64'd1);
    done_seen = done && rst_n;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (imem_we) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
      end
      if (done) done_cnt++;
    end
  end

  logic [7:0] stim[$];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random valid.
  task automatic drive_stream(input int mode);
    int   idx = 0;
    int   cyc = 0;
    logic ph  = 1'b1;
    logic v;
    logic acc;
    while (idx < stim.size() && cyc < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      bus.in_valid = v;
      bus.in_data  = v ? stim[idx] : 8'($urandom);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_val("bytes_consumed", idx, stim.size());
  endtask

  // Full session: start, drive stim, let the loader settle, compare with the model.
  task automatic run_session(input string tag, input int mode);
    int         wbase = wr_addr_q.size();
    int         abase = acc_cnt;
    int         dbase = done_cnt;
    int         n;
    bit         ok;
    logic [31:0] ea, ed;
    pulse_start();
    drive_stream(mode);
    for (int i = 0; i < 40; i++) begin
      if (cpu_run || err) break;
      @(posedge clk); #1;
    end
    check_val({tag, "_settle"}, {63'd0, cpu_run || err}, 64'd1);
    n  = (stim.size() >= 2) ? {stim[0], stim[1]} : 0;
    ok = (n != 0) && (n <= 64);
    check_val({tag, "_accepted"}, acc_cnt - abase, stim.size());
    if (ok) begin
      check_val({tag, "_nwrites"}, wr_addr_q.size() - wbase, n);
      for (int k = 0; k < n && wbase + k < wr_addr_q.size(); k++) begin
        ea = 32'(4 * k);
        ed = {stim[2 + 4*k], stim[3 + 4*k], stim[4 + 4*k], stim[5 + 4*k]};
        check_val({tag, "_addr"}, wr_addr_q[wbase + k], ea);
        check_val({tag, "_data"}, wr_data_q[wbase + k], ed);
        if (k == n - 1) begin
          check_val({tag, "_hold_addr"}, imem_addr, ea);
          check_val({tag, "_hold_data"}, imem_wdata, ed);
        end
      end
      check_val({tag, "_done"}, done_cnt - dbase, 1);
      check_val({tag, "_run"}, {63'd0, cpu_run}, 64'd1);
      check_val({tag, "_err"}, {63'd0, err}, 64'd0);
    end else begin
      check_val({tag, "_nwrites"}, wr_addr_q.size() - wbase, 0);
      check_val({tag, "_err"}, {63'd0, err}, 64'd1);
      check_val({tag, "_run"}, {63'd0, cpu_run}, 64'd0);
      check_val({tag, "_rdy"}, {63'd0, bus.in_ready}, 64'd0);
      check_val({tag, "_done"}, done_cnt - dbase, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rdy"}, {63'd0, bus.in_ready}, 64'd0);
    check_val({tag, "_we"}, {63'd0, imem_we}, 64'd0);
    check_val({tag, "_addr"}, imem_addr, 64'h0);
    check_val({tag, "_wdata"}, imem_wdata, 64'h0);
    check_val({tag, "_run"}, {63'd0, cpu_run}, 64'd0);
    check_val({tag, "_done"}, {63'd0, done}, 64'd0);
    check_val({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  task automatic make_random(input int n, input int ndata);
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    for (int i = 0; i < 4 * ndata; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    int wb;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word image, valid every cycle, then with valid toggling.
    stim = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h05, 8'hAC, 8'h10, 8'h00, 8'h00};
    for (int m = 0; m < 2; m++) begin
      wb = wr_data_q.size();
      run_session(m == 0 ? "basic" : "toggle", m);
      check_val("w0_lit", (wb < wr_data_q.size()) ? wr_data_q[wb] : 32'hx, 64'h20100005);
      check_val("w1_lit", (wb + 1 < wr_data_q.size()) ? wr_data_q[wb + 1] : 32'hx, 64'hAC100000);
    end

    // start while running: core back in reset, header phase ready.
    pulse_start();
    check_val("rerun_cpu_run", {63'd0, cpu_run}, 64'd0);
    check_val("rerun_rdy", {63'd0, bus.in_ready}, 64'd1);

    // Oversized header, recovery, zero-length header.
    stim = '{8'h00, 8'h41};
    run_session("too_big", 0);
    stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session("recover", 2);
    stim = '{8'h00, 8'h00};
    run_session("zero", 0);

    // Reset after the second data byte of word 0.
    wb = wr_addr_q.size();
    stim = '{8'h00, 8'h02, 8'h11, 8'h22};
    pulse_start();
    drive_stream(0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk);
    check_val("midrst_nowrite", wr_addr_q.size() - wb, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    make_random(3, 3);
    run_session("after_rst", 2);

    // Largest legal image.
    make_random(64, 64);
    run_session("max_n", 2);

    // Random sessions, some with illegal headers.
    for (int it = 0; it < 10; it++) begin
      if (it % 4 == 3) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 400);
        make_random(n, 0);
      end else begin
        n = $urandom_range(1, 6);
        make_random(n, n);
      end
      run_session("rand", $urandom_range(0, 2));
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
